// File: rtl/btb_update_queue_if.sv
// Update-request handshake between the commit path and the BTB write buffer.
interface btb_update_queue_if #(
  parameter int INDEX = 6,
  parameter int WIDTH = 32
);
  logic             upd_valid_i;
  logic [INDEX-1:0] upd_addr_i;
  logic [WIDTH-1:0] upd_data_i;
  logic             upd_ready_o;

  modport master (output upd_valid_i, upd_addr_i, upd_data_i, input upd_ready_o);
  modport slave  (input upd_valid_i, upd_addr_i, upd_data_i, output upd_ready_o);
endinterface

// File: rtl/btb_update_queue.sv
// Coalescing BTB write buffer: FIFO of pending index/entry updates draining one
// per cycle onto the BTB RAM write port, with lookup forwarding of queued data.
module btb_update_queue #(
  parameter int QDEPTH = 4,
  parameter int QINDEX = 2,
  parameter int INDEX  = 6,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  btb_update_queue_if.slave upd,
  input  logic              hold_i,
  output logic [INDEX-1:0]  wr_addr_o,
  output logic [WIDTH-1:0]  wr_data_o,
  output logic              we_o,
  input  logic [INDEX-1:0]  lookup_addr_i,
  output logic              fwd_hit_o,
  output logic [WIDTH-1:0]  fwd_data_o,
  output logic [QINDEX:0]   count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [QDEPTH-1:0] ent_valid;
  logic [INDEX-1:0]  ent_addr [QDEPTH];
  logic [WIDTH-1:0]  ent_data [QDEPTH];
  logic [QINDEX-1:0] head;
  logic [QINDEX-1:0] tail;
  logic [QINDEX:0]   count;

  logic              accept;
  logic              push;
  logic              coal_hit;
  logic [QINDEX-1:0] coal_idx;

  always_comb begin
    count_o  = count;
    empty_o  = (count == '0);
    full_o   = (count == (QINDEX+1)'(QDEPTH));
    // Reset suppresses the write so no pending update reaches the RAM once discarded.
    we_o     = !empty_o && !hold_i && !reset;
    wr_addr_o = empty_o ? '0 : ent_addr[head];
    wr_data_o = empty_o ? '0 : ent_data[head];
    upd.upd_ready_o = !full_o || we_o;
    accept   = upd.upd_valid_i && upd.upd_ready_o && !reset;

    // A popping head is excluded so a same-index request lands after it in write order.
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (ent_valid[i] && ent_addr[i] == upd.upd_addr_i &&
          !(we_o && QINDEX'(i) == head)) begin
        coal_hit = 1'b1;
        coal_idx = QINDEX'(i);
      end
    end
    push = accept && !coal_hit;

    // At most one valid entry per index, so OR-merging yields the unique match.
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (ent_valid[i] && ent_addr[i] == lookup_addr_i) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = fwd_data_o | ent_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (we_o) begin
        ent_valid[head] <= 1'b0;
        head            <= head + QINDEX'(1);
      end
      if (accept) begin
        if (coal_hit) begin
          ent_data[coal_idx] <= upd.upd_data_i;
        end else begin
          // When full and popping, tail equals head; this later write wins the slot.
          ent_valid[tail] <= 1'b1;
          ent_addr[tail]  <= upd.upd_addr_i;
          ent_data[tail]  <= upd.upd_data_i;
          tail            <= tail + QINDEX'(1);
        end
      end
      count <= count + (QINDEX+1)'(push) - (QINDEX+1)'(we_o);
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue against a list-based pending-update model.
module tb_btb_update_queue;

  localparam int QDEPTH = 4;
  localparam int QINDEX = 2;
  localparam int INDEX  = 6;
  localparam int WIDTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold_i;
  logic [INDEX-1:0]  wr_addr_o;
  logic [WIDTH-1:0]  wr_data_o;
  logic              we_o;
  logic [INDEX-1:0]  lookup_addr_i;
  logic              fwd_hit_o;
  logic [WIDTH-1:0]  fwd_data_o;
  logic [QINDEX:0]   count_o;
  logic              empty_o;
  logic              full_o;

  btb_update_queue_if #(.INDEX(INDEX), .WIDTH(WIDTH)) upd_if ();

  btb_update_queue #(.QDEPTH(QDEPTH), .QINDEX(QINDEX), .INDEX(INDEX), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .upd           (upd_if),
    .hold_i        (hold_i),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .we_o          (we_o),
    .lookup_addr_i (lookup_addr_i),
    .fwd_hit_o     (fwd_hit_o),
    .fwd_data_o    (fwd_data_o),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INDEX-1:0] a;
    logic [WIDTH-1:0] d;
  } ent_t;

  typedef struct {
    bit          we;
    bit          ready;
    int          count;
    bit          hit;
    logic [31:0] fdata;
  } stat_t;

  ent_t  pend[$];
  ent_t  wr_q[$];
  stat_t st_q[$];

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", n, act, exp, $time);
    end
  endfunction

  // One cycle: drive inputs, derive expected outputs from the pending list, then advance it.
  task automatic cycle(input bit v, input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d,
                       input bit h, input logic [INDEX-1:0] la, input bit r, output bit acc);
    stat_t s;
    bit drain, rdy, found;
    @(posedge clk);
    #1;
    upd_if.upd_valid_i = v;
    upd_if.upd_addr_i  = a;
    upd_if.upd_data_i  = d;
    hold_i             = h;
    lookup_addr_i      = la;
    reset              = r;

    drain = (pend.size() > 0) && !h && !r;
    rdy   = (pend.size() < QDEPTH) || drain;
    s.we = drain; s.ready = rdy; s.count = pend.size(); s.hit = 1'b0; s.fdata = '0;
    foreach (pend[i]) if (pend[i].a == la) begin s.hit = 1'b1; s.fdata = pend[i].d; end
    st_q.push_back(s);
    if (drain) wr_q.push_back(pend[0]);

    acc = v && rdy && !r;
    if (r) begin
      pend.delete();
    end else begin
      if (drain) void'(pend.pop_front());
      if (acc) begin
        found = 1'b0;
        foreach (pend[i]) if (pend[i].a == a) begin pend[i].d = d; found = 1'b1; end
        if (!found) pend.push_back('{a: a, d: d});
      end
    end
  endtask

  task automatic idle(input bit h, input logic [INDEX-1:0] la, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, h, la, 1'b0, acc);
  endtask

  task automatic push(input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d, input bit h,
                      input logic [INDEX-1:0] la);
    bit acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, a, d, h, la, 1'b0, acc);
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    stat_t s;
    ent_t  w;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("count", 64'(count_o), 64'(s.count));
      chk("empty", 64'(empty_o), 64'(s.count == 0));
      chk("full", 64'(full_o), 64'(s.count == QDEPTH));
      chk("ready", 64'(upd_if.upd_ready_o), 64'(s.ready));
      chk("we", 64'(we_o), 64'(s.we));
      chk("fwd_hit", 64'(fwd_hit_o), 64'(s.hit));
      chk("fwd_data", 64'(fwd_data_o), 64'(s.fdata));
      if (s.we) begin
        if (wr_q.size() == 0) begin
          chk("wr_underflow", 64'd0, 64'd1);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", 64'(wr_addr_o), 64'(w.a));
          chk("wr_data", 64'(wr_data_o), 64'(w.d));
        end
      end else if (s.count == 0) begin
        chk("wr_addr_idle", 64'(wr_addr_o), 64'd0);
        chk("wr_data_idle", 64'(wr_data_o), 64'd0);
      end
    end
  end

  initial begin
    bit acc;
    reset = 1'b1;
    hold_i = 1'b0;
    lookup_addr_i = '0;
    upd_if.upd_valid_i = 1'b1;
    upd_if.upd_addr_i  = 6'd1;
    upd_if.upd_data_i  = 32'h1;
    repeat (2) @(posedge clk);

    // Reset with a request present: nothing enqueued
    cycle(1'b1, 6'd1, 32'h11, 1'b0, 6'd1, 1'b1, acc);
    cycle(1'b1, 6'd1, 32'h11, 1'b0, 6'd1, 1'b1, acc);
    idle(1'b0, 6'd1, 2);

    // Single update
    push(6'd5, 32'h0000_1000, 1'b0, 6'd5);
    idle(1'b0, 6'd5, 3);

    // Fill under hold, fifth request waits, then drains in order
    for (int i = 1; i <= 4; i++) push(6'(i), 32'h100 + 32'(i), 1'b1, 6'(i));
    for (int i = 0; i < 3; i++) cycle(1'b1, 6'd9, 32'h900, 1'b1, 6'd9, 1'b0, acc);
    push(6'd9, 32'h900, 1'b0, 6'd9);
    idle(1'b0, 6'd9, 8);

    // Coalesce and forwarding
    push(6'd3, 32'hA, 1'b1, 6'd3);
    push(6'd7, 32'hB, 1'b1, 6'd7);
    push(6'd3, 32'hC, 1'b1, 6'd3);
    idle(1'b1, 6'd7, 1);
    idle(1'b1, 6'd8, 1);
    idle(1'b0, 6'd3, 4);

    // Head-pop collision
    push(6'd3, 32'hA, 1'b1, 6'd3);
    cycle(1'b1, 6'd3, 32'hD, 1'b0, 6'd3, 1'b0, acc);
    idle(1'b0, 6'd3, 3);

    // Reset mid-operation discards pending updates
    push(6'd10, 32'h10, 1'b1, 6'd10);
    push(6'd11, 32'h11, 1'b1, 6'd11);
    cycle(1'b1, 6'd12, 32'h12, 1'b0, 6'd10, 1'b1, acc);
    idle(1'b0, 6'd10, 3);

    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 99) < 60, 6'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 99) < 30, 6'($urandom_range(0, 7)),
            $urandom_range(0, 199) == 0, acc);
    idle(1'b0, '0, 10);

    @(posedge clk);
    @(negedge clk);
    chk("sb_status_left", 64'(st_q.size()), 64'd0);
    chk("sb_writes_left", 64'(wr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Small write-buffer between the branch-resolution/commit path and the BTB storage array. It accepts BTB update requests (index + packed entry word) through a valid/ready handshake and holds them in a FIFO. It drains at most one update per cycle onto the BTB RAM's single write port. Pending updates to the same index are coalesced, and pending data is forwarded to the fetch-side lookup so fetch never sees a stale entry that is already queued.

## Interface
- QDEPTH, 4: queue entries (power of two, ≥2)
- QINDEX, 2: log2(QDEPTH)
- INDEX, 6: BTB index width, matches BTB RAM address
- WIDTH, 32: packed BTB entry width, matches BTB RAM data
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- upd_valid_i  in  1  update request valid
- upd_addr_i  in  INDEX  BTB index to update
- upd_data_i  in  WIDTH  new entry word
- upd_ready_o  out  1  queue accepts request this cycle
- hold_i  in  1  suppress drain this cycle (recovery/array busy)
- wr_addr_o  out  INDEX  BTB RAM write index
- wr_data_o  out  WIDTH  BTB RAM write data
- we_o  out  1  BTB RAM write enable
- lookup_addr_i  in  INDEX  fetch-side BTB read index
- fwd_hit_o  out  1  lookup index matches a pending entry
- fwd_data_o  out  WIDTH  data of matching pending entry (0 when no hit)
- count_o  out  QINDEX+1  pending entries
- empty_o  out  1  count_o == 0
- full_o  out  1  count_o == QDEPTH

## Operation
- Storage: circular buffer of QDEPTH {valid, addr, data}, head/tail pointers mod QDEPTH, occupancy counter.
- Drain: we_o = !empty_o && !hold_i; wr_addr_o/wr_data_o = head entry (0 when empty). When we_o=1 the head pops at the same edge.
- upd_ready_o = !full_o || we_o. This is combinational and independent of upd_addr_i. Accept = upd_valid_i && upd_ready_o.
- Coalesce: on accept, if upd_addr_i matches a valid entry that is not the head being popped this cycle, that entry's data is overwritten in place. Position and count do not change.
- Otherwise the request is appended at the tail.
- Invariant: at most one valid entry per index, excluding the head during its pop cycle.
- Head-pop collision: if the incoming addr equals the popping head addr, the head writes its old data and the new request is appended. The RAM therefore receives the old value, then the new value.
- Push and pop in the same cycle while full: the push takes the freed slot, and count stays at QDEPTH.
- Forward: combinational compare of lookup_addr_i against all valid entries, including a popping head. Its data is not in the RAM until after the edge. The unique match drives fwd_data_o.
- Write order to the RAM is strict FIFO order of first insertion per index.

## Timing
- Reset state: all entries invalid, pointers 0, count_o=0, empty_o=1, full_o=0, we_o=0, wr_addr_o=0, wr_data_o=0, fwd_hit_o=0, fwd_data_o=0, upd_ready_o=1.
- Reset mid-operation: all pending updates are discarded, with no further writes. Any request presented in the reset cycle is dropped.
- Update accepted at edge N: it is visible on fwd_* in cycle N+1. It is visible on we_o in cycle N+1 if the queue was empty and hold_i=0. The RAM contains it after edge N+1.
- Throughput: one accept plus one drain per cycle sustained.
- hold_i: state is frozen except accepts. Accepts stall only when full.

## Test plan
- Reset: assert reset for 2 cycles with upd_valid_i=1 -> empty_o=1, we_o=0, count_o=0, upd_ready_o=1, nothing enqueued.
- Single update: addr 5, data 0x0000_1000, hold_i=0 -> next cycle we_o=1, wr_addr_o=5, wr_data_o=0x1000. Following cycle we_o=0, empty_o=1.
- Fill/backpressure: hold_i=1, push addrs 1,2,3,4 -> full_o=1, upd_ready_o=0, and a 5th request to addr 9 waits. Drop hold_i -> writes 1,2,3,4 on consecutive cycles. Addr 9 is accepted in the first drain cycle and written 5th.
- Coalesce: hold_i=1, push (3,A),(7,B),(3,C) -> count_o=2. Release -> writes (3,C) then (7,B).
- Forwarding: with (7,B) pending, lookup 7 -> fwd_hit_o=1, fwd_data_o=B. Lookup 8 -> fwd_hit_o=0, fwd_data_o=0.
- Head collision: head (3,A) popping while pushing (3,D) -> this cycle writes (3,A), a later cycle writes (3,D). Lookup 3 in the collision cycle -> A; next cycle -> D.
